// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller over valid/ready handshakes
//
// Purpose:
//    Accepts two WIDTH-bit operands, adds them LSB-first one bit per cycle
//    through a single full_adder and a carry flop, then presents the
//    registered WIDTH-bit sum and carry-out until the consumer takes them.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//    When defined, adds input `sub`. With sub=1, b is inverted at latch time
//    and the carry flop is loaded with 1, giving sum = a - b and cout = 1 for
//    no borrow.
//
// Ports:
//    clk        in   1      clock, rising edge
//    rst_n      in   1      asynchronous active-low reset
//    in_valid   in   1      operands valid
//    in_ready   out  1      high only in IDLE
//    a, b       in   WIDTH  operands
//    cin        in   1      carry into bit 0
//    sub        in   1      subtract select (SERIAL_ADDER_SUB_EN only)
//    out_valid  out  1      high only in DONE
//    out_ready  in   1      consumer accepts result
//    sum        out  WIDTH  registered result
//    cout       out  1      registered carry out of bit WIDTH-1
//    busy       out  1      high while in BUSY

module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
   half_adder u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

   assign co = c1 | c2;
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] sum_shifted;
   logic             last_bit;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;

   full_adder u_fa (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // New sum bit enters at the MSB end; after WIDTH shifts bit 0 lands at LSB.
   // Written as shift/or so WIDTH=1 needs no special slicing.
   assign sum_shifted = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
   assign last_bit    = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: a + ~b + 1; cin is ignored when sub=1.
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub | cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b_load;
               carry_d = carry_load;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            sum_sh_d = sum_shifted;
            carry_d  = fa_co;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            if (last_bit) begin
               // Counter holds on the last bit so it never wraps when WIDTH is a power of two.
               state_d = S_DONE;
               sum_d   = sum_shifted;
               cout_d  = fa_co;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_BUSY);
   assign out_valid = (state_q == S_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl (WIDTH=8)

module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         op_cin = 1'b0;
   logic         op_sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (op_a),
      .b         (op_b),
      .cin       (op_cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (op_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mc, input logic ms);
      int unsigned r;
      if (ms) r = int'(ma) + ((1 << W) - 1 - int'(mb)) + 1;
      else    r = int'(ma) + int'(mb) + int'(mc);
      return (W+1)'(r);
   endfunction

   // Starts at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tc,
                        input logic ts, output int lat, output logic [W-1:0] rs, output logic rc);
      op_a = ta; op_b = tb_b; op_cin = tc; op_sub = ts;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      rs = sum; rc = cout;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vecs[$];
      int           lat;
      logic [W-1:0] rs;
      logic         rc;
      logic [W:0]   exp;
      logic [W-1:0] ra, rb;
      logic         rci, rsub;

      vecs.push_back('{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0});
      vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
      vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
      vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
      vecs.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
      vecs.push_back('{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0});
      vecs.push_back('{8'h10, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0});
`endif

      // Reset state
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      #18 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors
      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, rs, rc);
         check($sformatf("vec%0d_latency", i), lat, W);
         check($sformatf("vec%0d_sum", i), rs, vecs[i].exp_sum);
         check($sformatf("vec%0d_cout", i), rc, vecs[i].exp_cout);
      end

      // Randomized against the arithmetic model
      for (int i = 0; i < 25; i++) begin
         ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         rsub = 1'($urandom);
`else
         rsub = 1'b0;
`endif
         exp = model(ra, rb, rci, rsub);
         do_op(ra, rb, rci, rsub, lat, rs, rc);
         check($sformatf("rand%0d_latency", i), lat, W);
         check($sformatf("rand%0d_result", i), {rc, rs}, exp);
      end

      // Backpressure: hold DONE for 5 cycles, in_valid pulses must be ignored
      op_a = 8'h35; op_b = 8'h4A; op_cin = 1'b0; op_sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_latency", lat, W);
      op_a = 8'hEE; op_b = 8'h11;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp%0d_out_valid", i), out_valid, 1);
         check($sformatf("bp%0d_in_ready", i), in_ready, 0);
         check($sformatf("bp%0d_result", i), {cout, sum}, 9'h07F);
         in_valid = (i % 2 == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_idle_in_ready", in_ready, 1);
      check("bp_idle_out_valid", out_valid, 0);
      check("bp_held_result", {cout, sum}, 9'h07F);
      @(posedge clk); #1;
      check("bp_no_stray_accept", in_ready, 1);
      check("bp_no_stray_busy", busy, 0);

      // Reset mid-operation
      do_op(8'h01, 8'h01, 1'b0, 1'b0, lat, rs, rc);
      check("pre_reset_sum", rs, 8'h02);
      op_a = 8'h55; op_b = 8'h0F; op_cin = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_busy_before_reset", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_sum", sum, 0);
      check("mid_rst_cout", cout, 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_out_valid", out_valid, 0);
      do_op(8'h12, 8'h34, 1'b0, 1'b0, lat, rs, rc);
      check("post_rst_latency", lat, W);
      check("post_rst_sum", rs, 8'h46);
      check("post_rst_cout", rc, 0);

      // Back-to-back with in_valid and out_ready held high
      begin
         logic [W-1:0] ba[3] = '{8'h11, 8'hF0, 8'h7F};
         logic [W-1:0] bb[3] = '{8'h22, 8'h20, 8'h01};
         int           acc_cyc[$];
         logic [W:0]   res[$];
         int           n_acc = 0;
         int           cyc = 0;
         bit           pending = 0;
         op_cin = 1'b0; op_sub = 1'b0;
         op_a = ba[0]; op_b = bb[0];
         in_valid = 1'b1;
         out_ready = 1'b1;
         while (res.size() < 3 && cyc < 200) begin
            if (out_valid) res.push_back({cout, sum});
            if (in_valid && in_ready) begin
               acc_cyc.push_back(cyc);
               n_acc++;
               pending = 1;
            end else if (pending) begin
               pending = 0;
               if (n_acc < 3) begin
                  op_a = ba[n_acc]; op_b = bb[n_acc];
               end else begin
                  in_valid = 1'b0;
               end
            end
            @(posedge clk); #1;
            cyc++;
         end
         in_valid = 1'b0;
         out_ready = 1'b0;
         check("b2b_accepts", acc_cyc.size(), 3);
         check("b2b_results", res.size(), 3);
         for (int i = 1; i < 3 && i < acc_cyc.size(); i++)
            check($sformatf("b2b_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], W + 2);
         for (int i = 0; i < 3 && i < res.size(); i++)
            check($sformatf("b2b_result%0d", i), res[i], model(ba[i], bb[i], 1'b0, 1'b0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
